// File: rtl/vc_wrr_lock_arb_pkg.sv
// Shared types for the weighted round-robin lock arbiter.
package vc_wrr_lock_arb_pkg;

  // What a cycle's transfer does to arbiter state.
  typedef enum logic [1:0] {
    FIRE_NONE,
    FIRE_MID,
    FIRE_END
  } fire_e;

endpackage

// File: rtl/vc_wrr_lock_arb_varb.sv
// Variable-priority arbitration chain: the highest-priority requester at or after
// the one-hot priority position wins, wrapping from the top index to 0.
module vc_VariableArbChain #(
  parameter int unsigned p_num_reqs = 2
) (
  input  logic                  kin,
  input  logic [p_num_reqs-1:0] priority_i,
  input  logic [p_num_reqs-1:0] reqs_i,
  output logic [p_num_reqs-1:0] grants_o,
  output logic                  kout_o
);

  localparam int unsigned N2 = 2 * p_num_reqs;

  logic [N2-1:0] reqs_x;
  logic [N2-1:0] pri_x;
  logic [N2-1:0] grants_x;
  logic [N2:0]   kills;

  // The request vector is doubled so that the wrap-around search is a linear chain.
  always_comb begin
    reqs_x   = {reqs_i, reqs_i};
    pri_x    = {{p_num_reqs{1'b0}}, priority_i};
    grants_x = '0;
    kills    = '0;
    kills[0] = 1'b1;
    for (int unsigned i = 0; i < N2; i++) begin
      if (pri_x[i]) begin
        grants_x[i]  = reqs_x[i];
        kills[i+1]   = reqs_x[i];
      end else begin
        grants_x[i]  = ~kills[i] & reqs_x[i];
        kills[i+1]   = kills[i] | grants_x[i];
      end
    end
    grants_o = kin ? '0 : (grants_x[p_num_reqs-1:0] | grants_x[N2-1:p_num_reqs]);
    kout_o   = kin | kills[N2];
  end

endmodule

// File: rtl/vc_wrr_lock_arb.sv
// Weighted round-robin arbiter with multi-flit packet locking; state advances
// only when a transfer fires (en && |grants).
module vc_wrr_lock_arb
  import vc_wrr_lock_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned WEIGHT_NBITS   = 4,
  parameter int unsigned RESET_PRIORITY = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              reqs,
  input  logic [NUM_REQS-1:0]              locks,
  input  logic [NUM_REQS*WEIGHT_NBITS-1:0] weights,
  input  logic                             en,
  output logic [NUM_REQS-1:0]              grants,
  output logic                             locked
);

  localparam logic [NUM_REQS-1:0]   PTR_RESET = {{(NUM_REQS-1){1'b0}}, 1'b1} << RESET_PRIORITY;
  localparam logic [WEIGHT_NBITS:0] CNT_ONE   = {{WEIGHT_NBITS{1'b0}}, 1'b1};

  function automatic logic [NUM_REQS-1:0] rotl1(input logic [NUM_REQS-1:0] v);
    return {v[NUM_REQS-2:0], v[NUM_REQS-1]};
  endfunction

  function automatic logic [WEIGHT_NBITS-1:0] weight_of(
    input logic [NUM_REQS*WEIGHT_NBITS-1:0] w,
    input logic [NUM_REQS-1:0]              sel
  );
    logic [WEIGHT_NBITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (sel[i]) r = r | w[i*WEIGHT_NBITS +: WEIGHT_NBITS];
    end
    return r;
  endfunction

  function automatic logic [WEIGHT_NBITS:0] eff_weight(input logic [WEIGHT_NBITS-1:0] w);
    return (w == '0) ? CNT_ONE : {1'b0, w};
  endfunction

  logic [NUM_REQS-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_NBITS-1:0] cnt_q, cnt_d;
  logic                    lock_q, lock_d;
  logic [NUM_REQS-1:0]     owner_q, owner_d;

  logic [NUM_REQS-1:0]     arb_grants;
  logic                    arb_kout;
  logic                    lock_hold;
  logic [WEIGHT_NBITS:0]   cnt_next;
  fire_e                   fire_kind;

  vc_VariableArbChain #(
    .p_num_reqs (NUM_REQS)
  ) u_arb (
    .kin        (1'b0),
    .priority_i (ptr_q),
    .reqs_i     (reqs),
    .grants_o   (arb_grants),
    .kout_o     (arb_kout)
  );

  always_comb begin
    // A lock whose owner has dropped its request is ignored; a fire then ends it.
    lock_hold = lock_q && |(owner_q & reqs);
    grants    = lock_hold ? owner_q : arb_grants;

    fire_kind = FIRE_NONE;
    if (en && |grants) begin
      fire_kind = |(grants & locks) ? FIRE_MID : FIRE_END;
    end

    lock_d   = (fire_kind == FIRE_MID);
    owner_d  = grants;
    cnt_next = (grants == ptr_q) ? ({1'b0, cnt_q} + CNT_ONE) : CNT_ONE;
    if (cnt_next >= eff_weight(weight_of(weights, grants))) begin
      ptr_d = rotl1(grants);
      cnt_d = '0;
    end else begin
      ptr_d = grants;
      cnt_d = cnt_next[WEIGHT_NBITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= PTR_RESET;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      if (fire_kind == FIRE_END) begin
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
      end
      if (fire_kind != FIRE_NONE) begin
        lock_q  <= lock_d;
        owner_q <= owner_d;
      end
    end
  end

  assign locked = lock_q;

  a_grants_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grants));
  a_ptr_onehot:     assert property (@(posedge clk) disable iff (reset) $onehot(ptr_q));
  a_kout_any_req:   assert property (@(posedge clk) disable iff (reset) arb_kout == |reqs);
  a_owner_holds:    assert property (@(posedge clk) disable iff (reset)
                                     !(lock_q && ~|(owner_q & reqs)))
                    else $warning("vc_wrr_lock_arb: lock owner dropped its request while locked");

endmodule

// File: tb/tb_vc_wrr_lock_arb.sv
// Directed-vector bench for vc_wrr_lock_arb (4 requesters, 4-bit weights, reset priority 0).
module tb_vc_wrr_lock_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  reqs;
  logic [3:0]  locks;
  logic [15:0] weights;
  logic        en;
  logic [3:0]  grants;
  logic        locked;

  int unsigned n_checks;
  int unsigned n_fails;

  vc_wrr_lock_arb #(
    .NUM_REQS       (4),
    .WEIGHT_NBITS   (4),
    .RESET_PRIORITY (0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .reqs    (reqs),
    .locks   (locks),
    .weights (weights),
    .en      (en),
    .grants  (grants),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqs  = '0;
    locks = '0;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Apply inputs, check combinational grants and registered locked, then clock once.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] lk, input logic e,
                     input logic [3:0] exp_g, input logic exp_lock);
    reqs  = r;
    locks = lk;
    en    = e;
    #1;
    check_eq({tag, ".grants"}, 32'(grants), 32'(exp_g));
    check_eq({tag, ".locked"}, 32'(locked), 32'(exp_lock));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    weights  = 16'h1111;

    // Reset state
    do_reset();
    reqs = 4'b0000;
    #1;
    check_eq("reset.grants_idle", 32'(grants), 32'h0);
    check_eq("reset.locked", 32'(locked), 32'h0);
    reqs = 4'b1111;
    #1;
    check_eq("reset.grants_ptr", 32'(grants), 32'h1);

    // Plain round robin
    cyc("rr0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("rr1", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
    cyc("rr2", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
    cyc("rr3", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
    cyc("rr4", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);

    // Weighted: req0 weight 3
    weights = 16'h1113;
    do_reset();
    cyc("w0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w1", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w2", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w3", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
    cyc("w4", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
    cyc("w5", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
    cyc("w6", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w7", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w8", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w9", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);

    // Lock with ptr at req2
    weights = 16'h1111;
    do_reset();
    cyc("lk_pre0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("lk_pre1", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
    cyc("lk_c1",   4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b0);
    cyc("lk_c2",   4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1);
    cyc("lk_c3",   4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);
    cyc("lk_c4",   4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);

    // Lock overrides priority when the owner is not at ptr
    do_reset();
    cyc("lko_c1", 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0);
    cyc("lko_c2", 4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1);
    cyc("lko_c3", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);
    cyc("lko_c4", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);

    // Stall: en low holds all state
    do_reset();
    cyc("st0", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0);
    cyc("st1", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0);
    cyc("st2", 4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b0);
    cyc("st3", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0);
    cyc("st4", 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("st5", 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b0);

    // Reset mid-packet while req3 owns the lock
    do_reset();
    cyc("rmp_c1", 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0);
    reqs  = 4'b1111;
    locks = 4'b1000;
    #1;
    check_eq("rmp_c2.grants", 32'(grants), 32'h8);
    check_eq("rmp_c2.locked", 32'(locked), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rmp_post.locked", 32'(locked), 32'h0);
    check_eq("rmp_post.grants", 32'(grants), 32'h1);

    // Weight 0 on req1 acts as weight 1
    weights = 16'h1101;
    do_reset();
    cyc("w0_0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("w0_1", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
    cyc("w0_2", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);

    // No requests for 3 cycles leaves ptr untouched
    weights = 16'h1111;
    do_reset();
    cyc("idle_pre", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("idle0",    4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc("idle1",    4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc("idle2",    4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc("idle_post", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);

    // Index wrap from ptr=1000
    do_reset();
    cyc("wr_pre0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("wr_pre1", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
    cyc("wr_pre2", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
    cyc("wr_wrap", 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0);
    cyc("wr_post", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
